// File: rtl/common_pkg.sv
// ---------------------------------------------------------------------------
// common : shared types, mode encodings and helpers for the data-memory path.
//   u4 / u64            : plain unsigned scalars used on pipeline ports
//   msize_t             : dbus transfer size
//   dbus_req_t          : valid, addr, size, strobe, data (master -> bus)
//   dbus_resp_t         : addr_ok, data_ok, data        (bus -> master)
//   MEM_LB .. MEM_SD    : memory-stage mode encodings; anything else = no access
//   mac_state_t         : mem_access_ctrl FSM states
//   mode_is_load/store  : mode classification
//   mode_misaligned     : natural-alignment check for a mode/offset pair
//   memoryHelper        : store strobe/data lane generation
// ---------------------------------------------------------------------------
package common;

    typedef logic [3:0]  u4;
    typedef logic [63:0] u64;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic    valid;
        u64      addr;
        msize_t  size;
        strobe_t strobe;
        u64      data;
    } dbus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u64   data;
    } dbus_resp_t;

    localparam u4 MEM_LB   = 4'b0000;
    localparam u4 MEM_LH   = 4'b0001;
    localparam u4 MEM_LW   = 4'b0010;
    localparam u4 MEM_LD   = 4'b0011;
    localparam u4 MEM_LBU  = 4'b0100;
    localparam u4 MEM_LHU  = 4'b0101;
    localparam u4 MEM_LWU  = 4'b0110;
    localparam u4 MEM_SB   = 4'b1000;
    localparam u4 MEM_SH   = 4'b1001;
    localparam u4 MEM_SW   = 4'b1010;
    localparam u4 MEM_SD   = 4'b1011;
    localparam u4 MEM_NONE = 4'b1111;

    typedef enum logic [1:0] {
        MAC_IDLE = 2'd0,
        MAC_BUS  = 2'd1,
        MAC_DONE = 2'd2
    } mac_state_t;

    typedef struct packed {
        strobe_t strobe;
        u64      data;
    } store_lane_t;

    function automatic logic mode_is_load(input u4 m);
        return (m[3] == 1'b0) && (m != 4'b0111);
    endfunction

    function automatic logic mode_is_store(input u4 m);
        return (m[3:2] == 2'b10);
    endfunction

    // mode[1:0] is log2(size) for every legal load and store encoding.
    function automatic logic mode_misaligned(input u4 m, input logic [2:0] a);
        logic r;
        case (m[1:0])
            2'b00:   r = 1'b0;
            2'b01:   r = a[0];
            2'b10:   r = |a[1:0];
            default: r = |a;
        endcase
        return r;
    endfunction

    // Illegal offsets yield an all-zero strobe so a misaligned store that
    // reaches the bus writes nothing.
    function automatic store_lane_t memoryHelper(input u4 m, input logic [2:0] a, input u64 wd);
        store_lane_t r;
        r = '0;
        case (m)
            MEM_SB: r.strobe = 8'h01 << a;
            MEM_SH: if (!a[0])          r.strobe = 8'h03 << a;
            MEM_SW: if (a[1:0] == 2'b0) r.strobe = 8'h0F << a;
            MEM_SD: if (a == 3'b0)      r.strobe = 8'hFF;
            default: r.strobe = 8'h00;
        endcase
        if (mode_is_store(m))
            r.data = wd << {a, 3'b000};
        return r;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// ---------------------------------------------------------------------------
// load_align : combinational load lane extraction and extension.
//   i_mode  : load mode (non-load modes produce 0)
//   i_lane  : byte offset addr[2:0]
//   i_data  : raw 64-bit bus read data
//   o_rdata : sign/zero extended result; ld passes i_data through
// ---------------------------------------------------------------------------
module load_align
    import common::*;
(
    input  u4          i_mode,
    input  logic [2:0] i_lane,
    input  u64         i_data,
    output u64         o_rdata
);

    logic [31:0] w_sh;

    assign w_sh = 32'(i_data >> {i_lane, 3'b000});

    always_comb begin
        o_rdata = '0;
        case (i_mode)
            MEM_LB:  o_rdata = {{56{w_sh[7]}},  w_sh[7:0]};
            MEM_LH:  o_rdata = {{48{w_sh[15]}}, w_sh[15:0]};
            MEM_LW:  o_rdata = {{32{w_sh[31]}}, w_sh[31:0]};
            MEM_LD:  o_rdata = i_data;
            MEM_LBU: o_rdata = {56'b0, w_sh[7:0]};
            MEM_LHU: o_rdata = {48'b0, w_sh[15:0]};
            MEM_LWU: o_rdata = {32'b0, w_sh[31:0]};
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl : one data-memory access per instruction, IDLE -> BUS -> DONE.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : access descriptor handshake (ready only in IDLE)
//   mem_mode/addr/wdata : access descriptor
//   dreq / dresp        : data bus request / response
//   out_valid/out_ready : result handshake to writeback
//   rdata               : extended load value, 0 for stores / no access
//   misalign            : trapped misaligned access flag
// Build option: MEM_MISALIGN_TRAP_EN - when defined, misaligned accesses skip
// the bus and complete with misalign=1; otherwise misalign is tied 0.
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import common::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  u4          mem_mode,
    input  u64         addr,
    input  u64         wdata,
    output dbus_req_t  dreq,
    input  dbus_resp_t dresp,
    output logic       out_valid,
    input  logic       out_ready,
    output u64         rdata,
    output logic       misalign
);

    mac_state_t  r_state;
    u4           r_mode;
    u64          r_addr;
    u64          r_wdata;
    u64          r_rdata;
    logic        w_access;
    logic        w_trap;
    u64          w_ld_val;
    store_lane_t w_st;
    logic        w_unused_addr_ok;

    assign w_unused_addr_ok = dresp.addr_ok;
    assign w_access         = mode_is_load(mem_mode) || mode_is_store(mem_mode);

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_misalign;
    assign w_trap   = w_access && mode_misaligned(mem_mode, addr[2:0]);
    assign misalign = r_misalign;

    always_ff @(posedge clk) begin
        if (reset)
            r_misalign <= 1'b0;
        else if (r_state == MAC_IDLE && in_valid)
            r_misalign <= w_trap;
    end
`else
    assign w_trap   = 1'b0;
    assign misalign = 1'b0;
`endif

    // Extraction works on the live response so the result is registered once.
    load_align u_load_align (
        .i_mode  (r_mode),
        .i_lane  (r_addr[2:0]),
        .i_data  (dresp.data),
        .o_rdata (w_ld_val)
    );

    assign w_st = memoryHelper(r_mode, r_addr[2:0], r_wdata);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MAC_IDLE;
            r_mode  <= MEM_NONE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                MAC_IDLE: if (in_valid) begin
                    r_mode  <= mem_mode;
                    r_addr  <= addr;
                    r_wdata <= wdata;
                    r_rdata <= '0;
                    r_state <= (!w_access || w_trap) ? MAC_DONE : MAC_BUS;
                end
                MAC_BUS: if (dresp.data_ok) begin
                    r_rdata <= w_ld_val;
                    r_state <= MAC_DONE;
                end
                MAC_DONE: if (out_ready) r_state <= MAC_IDLE;
                default:  r_state <= MAC_IDLE;
            endcase
        end
    end

    always_comb begin
        dreq = '0;
        if (r_state == MAC_BUS) begin
            dreq.valid  = 1'b1;
            dreq.addr   = r_addr;
            dreq.size   = MSIZE8;
            dreq.strobe = w_st.strobe;
            dreq.data   = w_st.data;
        end
    end

    assign in_ready  = (r_state == MAC_IDLE) && !reset;
    assign out_valid = (r_state == MAC_DONE);
    assign rdata     = r_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
    import common::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    u4          mem_mode;
    u64         addr;
    u64         wdata;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       out_valid;
    logic       out_ready;
    u64         rdata;
    logic       misalign;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_mode  (mem_mode),
        .addr      (addr),
        .wdata     (wdata),
        .dreq      (dreq),
        .dresp     (dresp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rdata     (rdata),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are checked at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input u4 m, input u64 a, input u64 wd);
        in_valid = 1'b1; mem_mode = m; addr = a; wdata = wd;
        tick();
        in_valid = 1'b0; mem_mode = MEM_NONE; addr = '0; wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; mem_mode = MEM_NONE; addr = '0; wdata = '0;
        out_ready = 1'b0; dresp = '0;
        dresp.data_ok = 1'b1;             // stale response during reset
        dresp.data    = 64'hDEAD_BEEF_DEAD_BEEF;
        tick(); tick();
        @(negedge clk);
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (dreq.valid !== 1'b0 || dreq.strobe !== 8'h00) begin errors++; $display("FAIL reset_dreq: got v=%b s=%h expected v=0 s=00", dreq.valid, dreq.strobe); end
        checks++;
        if (rdata !== 64'h0 || misalign !== 1'b0) begin errors++; $display("FAIL reset_rdata: got %h/%b expected 0/0", rdata, misalign); end
        checks++;
        tick();
        reset = 1'b0;                     // data_ok still high in first IDLE cycle
        @(negedge clk);
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        tick();
        dresp = '0;
        @(negedge clk);
        if (out_valid !== 1'b0 || dreq.valid !== 1'b0) begin errors++; $display("FAIL stale_data_ok: got ov=%b dv=%b expected 0/0", out_valid, dreq.valid); end
        checks++;
    endtask

    task automatic test_lb();
        accept(MEM_LB, 64'h1003, 64'h0);
        @(negedge clk);
        if (dreq.valid !== 1'b1 || dreq.addr !== 64'h1003 || dreq.size !== MSIZE8 || dreq.strobe !== 8'h00) begin
            errors++; $display("FAIL lb_dreq: got v=%b a=%h sz=%0d s=%h expected 1/1003/3/00", dreq.valid, dreq.addr, dreq.size, dreq.strobe);
        end
        checks++;
        tick();                           // cycle 2
        tick();                           // cycle 3: data_ok
        dresp.data_ok = 1'b1; dresp.data = 64'h0000_0000_80FF_0000;
        @(negedge clk);
        if (out_valid !== 1'b0) begin errors++; $display("FAIL lb_early_out_valid: got %b expected 0", out_valid); end
        checks++;
        tick();                           // cycle 4
        dresp = '0;
        @(negedge clk);
        if (out_valid !== 1'b1 || rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_result: got ov=%b rdata=%h expected 1/ffffffffffffff80", out_valid, rdata); end
        checks++;
        if (dreq.valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL lb_done_ctrl: got dv=%b ir=%b expected 0/0", dreq.valid, in_ready); end
        checks++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        @(negedge clk);
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL lb_return_idle: got ov=%b ir=%b expected 0/1", out_valid, in_ready); end
        checks++;
    endtask

    task automatic test_lhu();
        accept(MEM_LHU, 64'h1006, 64'h0);
        dresp.data_ok = 1'b1; dresp.data = 64'hABCD_0000_0000_0000;   // cycle 1
        tick();
        dresp = '0;
        @(negedge clk);
        if (out_valid !== 1'b1 || rdata !== 64'h0000_0000_0000_ABCD) begin errors++; $display("FAIL lhu_result: got ov=%b rdata=%h expected 1/abcd", out_valid, rdata); end
        checks++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_sw();
        accept(MEM_SW, 64'h2004, 64'h1122_3344_5566_7788);
        @(negedge clk);
        if (dreq.valid !== 1'b1 || dreq.strobe !== 8'hF0 || dreq.data !== 64'h5566_7788_0000_0000) begin
            errors++; $display("FAIL sw_dreq: got v=%b s=%h d=%h expected 1/f0/5566778800000000", dreq.valid, dreq.strobe, dreq.data);
        end
        checks++;
        tick();                           // still in BUS, fields stable
        @(negedge clk);
        if (dreq.strobe !== 8'hF0 || dreq.addr !== 64'h2004) begin errors++; $display("FAIL sw_stable: got s=%h a=%h expected f0/2004", dreq.strobe, dreq.addr); end
        checks++;
        dresp.data_ok = 1'b1; dresp.data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        dresp = '0;
        @(negedge clk);
        if (out_valid !== 1'b1 || rdata !== 64'h0) begin errors++; $display("FAIL sw_result: got ov=%b rdata=%h expected 1/0", out_valid, rdata); end
        checks++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_sb_sd();
        accept(MEM_SB, 64'h5005, 64'h0000_0000_0000_00AB);
        @(negedge clk);
        if (dreq.strobe !== 8'h20 || dreq.data !== 64'h0000_AB00_0000_0000) begin errors++; $display("FAIL sb_dreq: got s=%h d=%h expected 20/0000ab0000000000", dreq.strobe, dreq.data); end
        checks++;
        dresp.data_ok = 1'b1; tick(); dresp = '0;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        accept(MEM_SD, 64'h5000, 64'h0102_0304_0506_0708);
        @(negedge clk);
        if (dreq.strobe !== 8'hFF || dreq.data !== 64'h0102_0304_0506_0708) begin errors++; $display("FAIL sd_dreq: got s=%h d=%h expected ff/0102030405060708", dreq.strobe, dreq.data); end
        checks++;
        dresp.data_ok = 1'b1; tick(); dresp = '0;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_misalign();
        accept(MEM_SH, 64'h2001, 64'h0000_0000_0000_BEEF);
        @(negedge clk);
`ifdef MEM_MISALIGN_TRAP_EN
        if (dreq.valid !== 1'b0 || out_valid !== 1'b1 || misalign !== 1'b1 || rdata !== 64'h0) begin
            errors++; $display("FAIL misalign_trap: got dv=%b ov=%b mis=%b rd=%h expected 0/1/1/0", dreq.valid, out_valid, misalign, rdata);
        end
        checks++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
`else
        if (dreq.valid !== 1'b1 || dreq.strobe !== 8'h00 || misalign !== 1'b0) begin
            errors++; $display("FAIL misalign_issue: got dv=%b s=%h mis=%b expected 1/00/0", dreq.valid, dreq.strobe, misalign);
        end
        checks++;
        dresp.data_ok = 1'b1; tick(); dresp = '0;
        @(negedge clk);
        if (out_valid !== 1'b1 || misalign !== 1'b0) begin errors++; $display("FAIL misalign_done: got ov=%b mis=%b expected 1/0", out_valid, misalign); end
        checks++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
`endif
    endtask

    task automatic test_hold();
        accept(MEM_LW, 64'h3004, 64'h0);
        dresp.data_ok = 1'b1; dresp.data = 64'h8765_4321_0000_0000;
        tick();
        dresp = '0;
        in_valid = 1'b1; mem_mode = MEM_LD; addr = 64'h7000;   // must not be taken
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || rdata !== 64'hFFFF_FFFF_8765_4321) begin
                errors++; $display("FAIL hold_%0d: got ov=%b ir=%b rd=%h expected 1/0/ffffffff87654321", i, out_valid, in_ready, rdata);
            end
            checks++;
            tick();
        end
        in_valid = 1'b0; mem_mode = MEM_NONE; addr = '0;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        tick();
        @(negedge clk);
        if (dreq.valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL hold_not_accepted: got dv=%b ov=%b ir=%b expected 0/0/1", dreq.valid, out_valid, in_ready);
        end
        checks++;
    endtask

    task automatic test_reset_mid_bus();
        accept(MEM_LD, 64'h4000, 64'h0);
        reset = 1'b1;                     // cycle 1, in BUS
        tick();
        reset = 1'b0;
        @(negedge clk);
        if (dreq.valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_bus: got dv=%b ov=%b ir=%b expected 0/0/1", dreq.valid, out_valid, in_ready);
        end
        checks++;
        tick();
        dresp.data_ok = 1'b1; dresp.data = 64'h1234;   // stray response
        tick();
        dresp = '0;
        @(negedge clk);
        if (out_valid !== 1'b0 || dreq.valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL stray_data_ok: got ov=%b dv=%b ir=%b expected 0/0/1", out_valid, dreq.valid, in_ready);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        accept(MEM_NONE, 64'h0, 64'h0);
        @(negedge clk);
        if (out_valid !== 1'b1 || dreq.valid !== 1'b0 || rdata !== 64'h0) begin errors++; $display("FAIL noaccess: got ov=%b dv=%b rd=%h expected 1/0/0", out_valid, dreq.valid, rdata); end
        checks++;
        out_ready = 1'b1; in_valid = 1'b1; mem_mode = 4'b0111;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_bypass: got ir=%b expected 0", in_ready); end
        checks++;
        tick();                           // IDLE cycle, second descriptor taken here
        out_ready = 1'b0;
        @(negedge clk);
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got ir=%b ov=%b expected 1/0", in_ready, out_valid); end
        checks++;
        tick();
        in_valid = 1'b0; mem_mode = MEM_NONE;
        @(negedge clk);
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got ov=%b expected 1", out_valid); end
        checks++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lhu();
        test_sw();
        test_sb_sd();
        test_misalign();
        test_hold();
        test_reset_mid_bus();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
